cic_decim_ctrl: RTL

Sequencer for the CIC decimator. Takes the integrator chain's output handshake, divides it by a programmable rate R, and issues one decimation strobe per R samples to the comb section. Owns the chain-wide clear, the comb warm-up blanking, and safe runtime rate changes. Sits between the integrator chain output and the comb chain input.

---
 rtl/cic_pkg.sv | 16 +
 rtl/cic_rate_counter.sv | 27 ++
 rtl/cic_decim_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared state encoding, rate constants and rate clamp for the CIC control blocks.
package cic_pkg;
  localparam int CIC_RATE_W       = 8;
  localparam int CIC_DEFAULT_RATE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } cic_state_t;

  // A zero rate has no meaning for a divider; treat it as pass-through.
  function automatic logic [31:0] clamp_rate(input logic [31:0] r);
    return (r == 32'd0) ? 32'd1 : r;
  endfunction
endpackage

// File: rtl/cic_rate_counter.sv
// Modulo-rate sample counter; wrap is combinational on the sample that completes a group.
module cic_rate_counter #(
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic [RW-1:0] rate,
  output logic          wrap
);
  logic [RW-1:0] count;
  logic [RW-1:0] last;

  assign last = rate - RW'(1);
  assign wrap = advance && (count == last);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (advance) begin
      count <= count + RW'(1);
    end
  end
endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: rate divide, chain clear, comb warm-up blanking, safe rate changes.
// CIC_DECIM_CTRL_STATUS_EN adds the out_count / overrun status ports.
module cic_decim_ctrl import cic_pkg::*; #(
  parameter int M            = 1,
  parameter int RW           = CIC_RATE_W,
  parameter int CLEAR_CYCLES = 2,
  parameter int DEFAULT_RATE = CIC_DEFAULT_RATE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [RW-1:0] cfg_rate,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          in_valid,
  output logic          dec_strobe,
  output logic          out_valid,
  output logic          chain_clear,
  output logic          busy
`ifdef CIC_DECIM_CTRL_STATUS_EN
  ,
  output logic [15:0]   out_count,
  output logic          overrun
`endif
);
  localparam int WW = $clog2(M + 1);
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  cic_state_t    state, next_state;
  logic [RW-1:0] rate, pend_rate, new_rate;
  logic          pending;
  logic [WW-1:0] warm;
  logic          warm_done;
  logic [CW-1:0] clr_cnt;
  logic          clr_done;
  logic          wrap, advance, cfg_acc;

  assign new_rate  = RW'(clamp_rate(32'(cfg_rate)));
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign warm_done = (warm == WW'(M));
  assign clr_done  = (clr_cnt == CW'(CLEAR_CYCLES - 1));
  assign advance   = rst && (state == RUN) && in_valid;

  cic_rate_counter #(.RW(RW)) u_rate_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != RUN),
    .advance (advance),
    .rate    (rate),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = CLEAR;
      CLEAR:   if (clr_done) next_state = enable ? RUN : IDLE;
      RUN: begin
        if (!enable)              next_state = IDLE;
        else if (wrap && pending) next_state = CLEAR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Everything is gated by rst so the reset cycle itself shows reset values.
  always_comb begin
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    chain_clear = !rst;
    dec_strobe  = 1'b0;
    out_valid   = 1'b0;
    if (rst) begin
      case (state)
        IDLE:  cfg_ready = 1'b1;
        CLEAR: begin
          chain_clear = 1'b1;
          busy        = 1'b1;
        end
        RUN: begin
          busy       = 1'b1;
          cfg_ready  = !pending;
          dec_strobe = wrap;
          out_valid  = wrap && warm_done;
        end
        default: ;
      endcase
    end
  end

  // A rate taken while running waits for the next group boundary so no group is split.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rate      <= RW'(DEFAULT_RATE);
      pend_rate <= '0;
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cfg_acc) rate <= new_rate;
        RUN: begin
          if (next_state != RUN) begin
            pending <= 1'b0;
            if (pending)      rate <= pend_rate;
            else if (cfg_acc) rate <= new_rate;
          end else if (cfg_acc) begin
            pend_rate <= new_rate;
            pending   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || state == CLEAR) warm <= '0;
    else if (dec_strobe && !warm_done) warm <= warm + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst || state != CLEAR || clr_done) clr_cnt <= '0;
    else                                    clr_cnt <= clr_cnt + CW'(1);
  end

`ifdef CIC_DECIM_CTRL_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rst || state == CLEAR) out_count <= '0;
    else if (out_valid)         out_count <= out_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst)                        overrun <= 1'b0;
    else if (cfg_valid && pending)   overrun <= 1'b1;
  end
`endif
endmodule
